// File: rtl/if_id_pipeline_register.sv
// IF/ID pipeline register: holds fetched instruction, PC and next-PC for decode
// behind a two-entry skid buffer so that in_ready is a registered signal.
module if_id_pipeline_register #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTN = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instn,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_nextpc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instn,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_nextpc,
  output logic              out_misalign,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

  occ_e              state;
  logic [DATA_W-1:0] skid_instn;
  logic [DATA_W-1:0] skid_pc;
  logic [DATA_W-1:0] skid_nextpc;
  logic              skid_misalign;

  logic accept;
  logic drain;
  logic in_misalign;

  assign accept      = in_valid & in_ready;
  assign drain       = out_valid & out_ready;
  assign in_misalign = |in_pc[1:0];

  // in_ready is a pure function of the registered occupancy (high unless TWO),
  // so back-pressure never forms a combinational path from out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= EMPTY;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_instn     <= NOP_INSTN;
      out_pc        <= '0;
      out_nextpc    <= '0;
      out_misalign  <= 1'b0;
      // NOTE: the skid entry is ordinary flops, not a RAM, so it is reset to a
      // known value instead of being left to power up as X.
      skid_instn    <= '0;
      skid_pc       <= '0;
      skid_nextpc   <= '0;
      skid_misalign <= 1'b0;
      stall_count   <= '0;
    end else begin
      // NOTE: every register here uses <= so each branch reads the values
      // from before this edge, independent of statement order.
      if (out_valid && !out_ready && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;

      if (flush) begin
        state        <= EMPTY;
        in_ready     <= 1'b1;
        out_valid    <= 1'b0;
        out_instn    <= NOP_INSTN;
        out_misalign <= 1'b0;
      end else begin
        unique case (state)
          EMPTY: begin
            if (accept) begin
              state        <= ONE;
              out_valid    <= 1'b1;
              out_instn    <= in_instn;
              out_pc       <= in_pc;
              out_nextpc   <= in_nextpc;
              out_misalign <= in_misalign;
            end
          end
          ONE: begin
            if (accept && drain) begin
              out_instn    <= in_instn;
              out_pc       <= in_pc;
              out_nextpc   <= in_nextpc;
              out_misalign <= in_misalign;
            end else if (accept) begin
              state         <= TWO;
              in_ready      <= 1'b0;
              skid_instn    <= in_instn;
              skid_pc       <= in_pc;
              skid_nextpc   <= in_nextpc;
              skid_misalign <= in_misalign;
            end else if (drain) begin
              // PC fields keep their last values; only the instruction is NOPed.
              state        <= EMPTY;
              out_valid    <= 1'b0;
              out_instn    <= NOP_INSTN;
              out_misalign <= 1'b0;
            end
          end
          TWO: begin
            if (drain) begin
              state        <= ONE;
              in_ready     <= 1'b1;
              out_instn    <= skid_instn;
              out_pc       <= skid_pc;
              out_nextpc   <= skid_nextpc;
              out_misalign <= skid_misalign;
            end
          end
          default: begin
            state        <= EMPTY;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_instn    <= NOP_INSTN;
            out_misalign <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
